fetch_align_queue: RTL and testbench

- Instruction prefetch/alignment queue that produces the 128-bit IR window, its EIP and a valid bit for the decode stages.
- Fetches 16-byte-aligned lines from the I-cache into a two-line circular byte buffer.
- Presents the 16 bytes that start at the current EIP.
- Retires bytes when decode reports the length of each consumed instruction; a flush redirects fetch to a new EIP.

---
 rtl/fetch_align_queue_pkg.sv | 13 +
 rtl/fetch_align_queue_byte_rotator32.sv | 21 ++
 rtl/fetch_align_queue.sv | 132 +++++++++++++
 tb/tb_fetch_align_queue.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_align_queue_pkg.sv
// Shared constants and FSM encoding for the instruction fetch/alignment queue.
package fetch_align_queue_pkg;

    localparam int unsigned LINE_BYTES  = 16;
    localparam int unsigned QUEUE_SLOTS = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_DISCARD = 2'b10
    } fsm_state_t;

endpackage

// File: rtl/fetch_align_queue_byte_rotator32.sv
// Byte-granular right rotate of a 32-byte buffer; returns the low 16 bytes.
module byte_rotator32 (
    input  logic [255:0] i_buf,
    input  logic [4:0]   i_rot,
    output logic [127:0] o_win
);

    logic [255:0] w_stage [0:5];

    // Five 2:1 mux ranks rotating by 1, 2, 4, 8 and 16 bytes.
    always_comb begin
        w_stage[0] = i_buf;
        for (int unsigned s = 0; s < 5; s++) begin
            w_stage[s+1] = i_rot[s] ?
                ((w_stage[s] >> (8 << s)) | (w_stage[s] << (256 - (8 << s)))) :
                w_stage[s];
        end
        o_win = w_stage[5][127:0];
    end

endmodule

// File: rtl/fetch_align_queue.sv
// Two-line circular prefetch buffer presenting the 16 bytes at EIP to decode.
module fetch_align_queue
    import fetch_align_queue_pkg::*;
#(
    parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         FLUSH,
    input  logic [31:0]  FLUSH_EIP,
    output logic         ICACHE_RD_REQ,
    output logic [31:0]  ICACHE_RD_ADDR,
    input  logic         ICACHE_RD_ACK,
    input  logic [127:0] ICACHE_RD_DATA,
    output logic [127:0] IR,
    output logic         IR_V,
    output logic [31:0]  EIP_OUT,
    input  logic         D1_ADVANCE,
    input  logic [3:0]   instr_length_updt,
    output logic [5:0]   Q_BYTES
);

    fsm_state_t   r_state;
    fsm_state_t   w_state_nxt;
    logic [127:0] r_slot [0:QUEUE_SLOTS-1];
    logic [1:0]   r_slot_v;
    logic         r_hs;
    logic [3:0]   r_off;
    logic [31:0]  r_eip;
    logic [31:0]  r_fetch_addr;
    logic [31:0]  r_req_addr;
    logic         r_ign_ack;

    logic [1:0]   w_nvalid;
    logic         w_fs;
    logic         w_ack;
    logic         w_fill;
    logic         w_adv;
    logic [4:0]   w_off_sum;
    logic [1:0]   w_slot_v_nxt;
    logic [31:0]  w_fetch_nxt;
    logic [127:0] w_win;

    assign w_nvalid  = {1'b0, r_slot_v[0]} + {1'b0, r_slot_v[1]};
    assign w_fs      = r_hs ^ (w_nvalid == 2'd1);
    assign Q_BYTES   = r_slot_v[r_hs] ? ({w_nvalid, 4'b0000} - {2'b00, r_off}) : '0;
    assign IR_V      = (Q_BYTES >= 6'(LINE_BYTES));
    assign w_ack     = ICACHE_RD_ACK & ~r_ign_ack;
    assign w_fill    = w_ack & (r_state == ST_REQ) & ~FLUSH;
    assign w_adv     = D1_ADVANCE & IR_V & ~FLUSH & (instr_length_updt != 4'd0);
    assign w_off_sum = {1'b0, r_off} + {1'b0, instr_length_updt};

    // Fill uses the slot free at cycle start; a retire may free the head in parallel.
    always_comb begin
        w_slot_v_nxt = r_slot_v;
        w_fetch_nxt  = r_fetch_addr;
        if (FLUSH) begin
            w_slot_v_nxt = '0;
            w_fetch_nxt  = {FLUSH_EIP[31:4], 4'b0000};
        end else begin
            if (w_fill) begin
                w_slot_v_nxt[w_fs] = 1'b1;
                w_fetch_nxt        = r_fetch_addr + 32'(LINE_BYTES);
            end
            if (w_adv && w_off_sum[4]) begin
                w_slot_v_nxt[r_hs] = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        ICACHE_RD_REQ = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!FLUSH && (w_slot_v_nxt != 2'b11)) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                ICACHE_RD_REQ = 1'b1;
                if (FLUSH)      w_state_nxt = w_ack ? ST_REQ : ST_DISCARD;
                else if (w_ack) w_state_nxt = (w_slot_v_nxt != 2'b11) ? ST_REQ : ST_IDLE;
            end
            ST_DISCARD: begin
                ICACHE_RD_REQ = 1'b1;
                if (w_ack) w_state_nxt = ST_REQ;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_slot_v     <= '0;
            r_hs         <= 1'b0;
            r_off        <= RESET_EIP[3:0];
            r_eip        <= RESET_EIP;
            r_fetch_addr <= {RESET_EIP[31:4], 4'b0000};
            r_req_addr   <= {RESET_EIP[31:4], 4'b0000};
            r_ign_ack    <= r_ign_ack | (r_state != ST_IDLE);
            r_slot[0]    <= '0;
            r_slot[1]    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_slot_v     <= w_slot_v_nxt;
            r_fetch_addr <= w_fetch_nxt;
            r_ign_ack    <= 1'b0;
            // The address of an in-flight stale request must stay put until its ACK.
            if (w_state_nxt != ST_DISCARD) r_req_addr <= w_fetch_nxt;
            if (w_fill) r_slot[w_fs] <= ICACHE_RD_DATA;
            if (FLUSH) begin
                r_hs  <= 1'b0;
                r_off <= FLUSH_EIP[3:0];
                r_eip <= FLUSH_EIP;
            end else if (w_adv) begin
                {r_hs, r_off} <= {r_hs, r_off} + {1'b0, instr_length_updt};
                r_eip         <= r_eip + {28'b0, instr_length_updt};
            end
        end
    end

    byte_rotator32 u_rot (
        .i_buf (r_slot_v == 2'b00 ? 256'b0 : {r_slot[1], r_slot[0]}),
        .i_rot ({r_hs, r_off}),
        .o_win (w_win)
    );

    assign IR             = w_win;
    assign EIP_OUT        = r_eip;
    assign ICACHE_RD_ADDR = r_req_addr;

endmodule

// File: tb/tb_fetch_align_queue.sv
// Directed vector bench for fetch_align_queue with a few hand-written sequences.
module tb_fetch_align_queue;

    logic         clk = 1'b0;
    logic         reset;
    logic         FLUSH;
    logic [31:0]  FLUSH_EIP;
    logic         ICACHE_RD_REQ;
    logic [31:0]  ICACHE_RD_ADDR;
    logic         ICACHE_RD_ACK;
    logic [127:0] ICACHE_RD_DATA;
    logic [127:0] IR;
    logic         IR_V;
    logic [31:0]  EIP_OUT;
    logic         D1_ADVANCE;
    logic [3:0]   instr_length_updt;
    logic [5:0]   Q_BYTES;

    int errors = 0;
    int checks = 0;

    fetch_align_queue #(.RESET_EIP(32'h0000_1000)) dut (
        .clk               (clk),
        .reset             (reset),
        .FLUSH             (FLUSH),
        .FLUSH_EIP         (FLUSH_EIP),
        .ICACHE_RD_REQ     (ICACHE_RD_REQ),
        .ICACHE_RD_ADDR    (ICACHE_RD_ADDR),
        .ICACHE_RD_ACK     (ICACHE_RD_ACK),
        .ICACHE_RD_DATA    (ICACHE_RD_DATA),
        .IR                (IR),
        .IR_V              (IR_V),
        .EIP_OUT           (EIP_OUT),
        .D1_ADVANCE        (D1_ADVANCE),
        .instr_length_updt (instr_length_updt),
        .Q_BYTES           (Q_BYTES)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n;
        logic         fl;
        logic [31:0]  feip;
        logic         ack;
        logic [127:0] data;
        logic         adv;
        logic [3:0]   len;
        logic         chk;
        logic         ereq;
        logic [31:0]  eaddr;
        logic         eirv;
        logic [31:0]  eeip;
        logic [5:0]   eq;
        logic         chk_ir;
        logic [127:0] eir;
    } vec_t;

    vec_t tv[$];

    function automatic logic [127:0] mk(input logic [7:0] seed);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = seed + 8'(i);
        return r;
    endfunction

    // Expected window: slot0 = a, slot1 = b, read pointer = off.
    function automatic logic [127:0] win(input logic [127:0] a, input logic [127:0] b, input int off);
        logic [255:0] bb;
        logic [127:0] r;
        bb = {b, a};
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = bb[((off + i) % 32)*8 +: 8];
        return r;
    endfunction

    task automatic cmp(input string nm, input int row, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h, expected %h", nm, row, got, exp);
        end
    endtask

    task automatic add(input logic rst_n, input logic fl, input logic [31:0] feip,
                       input logic ack, input logic [127:0] data, input logic adv, input logic [3:0] len,
                       input logic chk, input logic ereq, input logic [31:0] eaddr, input logic eirv,
                       input logic [31:0] eeip, input logic [5:0] eq, input logic chk_ir, input logic [127:0] eir);
        vec_t v;
        v.rst_n = rst_n; v.fl = fl; v.feip = feip; v.ack = ack; v.data = data; v.adv = adv; v.len = len;
        v.chk = chk; v.ereq = ereq; v.eaddr = eaddr; v.eirv = eirv; v.eeip = eeip; v.eq = eq;
        v.chk_ir = chk_ir; v.eir = eir;
        tv.push_back(v);
    endtask

    task automatic drive_idle();
        reset = 1'b1; FLUSH = 1'b0; FLUSH_EIP = '0; ICACHE_RD_ACK = 1'b0;
        ICACHE_RD_DATA = '0; D1_ADVANCE = 1'b0; instr_length_updt = '0;
    endtask

    initial begin
        logic [127:0] Z, S, L0, L1, L2, M0, M1, N0, N1, N2, P0, Q0, Q1, R0, R1;
        int n;
        Z  = '0;        S  = mk(8'hEE);
        L0 = mk(8'h00); L1 = mk(8'h10); L2 = mk(8'h20);
        M0 = mk(8'h40); M1 = mk(8'h50);
        N0 = mk(8'h80); N1 = mk(8'h90); N2 = mk(8'hA0);
        P0 = mk(8'hC0); Q0 = mk(8'hD0); Q1 = mk(8'h60);
        R0 = mk(8'h30); R1 = mk(8'h70);

        //  rst fl feip          ack data adv len  chk req addr          irv eip           q   cir ir
        add(0, 0, 32'h0,        0, Z,  0, 0,   0, 0, 32'h0,        0, 32'h0,        0,  0, Z);
        add(1, 0, 32'h0,        0, Z,  0, 0,   1, 0, 32'h0,        0, 32'h0000_1000, 0,  0, Z);
        add(1, 0, 32'h0,        1, L0, 0, 0,   1, 1, 32'h0000_1000, 0, 32'h0000_1000, 0,  0, Z);
        add(1, 0, 32'h0,        1, L1, 0, 0,   1, 1, 32'h0000_1010, 1, 32'h0000_1000, 16, 1, L0);
        add(1, 0, 32'h0,        0, Z,  0, 0,   1, 0, 32'h0,        1, 32'h0000_1000, 32, 1, L0);
        add(1, 0, 32'h0,        0, Z,  1, 7,   1, 0, 32'h0,        1, 32'h0000_1000, 32, 0, Z);
        add(1, 0, 32'h0,        0, Z,  1, 9,   1, 0, 32'h0,        1, 32'h0000_1007, 25, 1, win(L0, L1, 7));
        add(1, 0, 32'h0,        0, Z,  0, 0,   1, 1, 32'h0000_1020, 1, 32'h0000_1010, 16, 1, L1);
        add(1, 0, 32'h0,        1, L2, 0, 0,   1, 1, 32'h0000_1020, 1, 32'h0000_1010, 16, 0, Z);
        add(1, 0, 32'h0,        0, Z,  1, 0,   1, 0, 32'h0,        1, 32'h0000_1010, 32, 1, L1);
        add(1, 1, 32'h0000_200C, 0, Z, 1, 3,   1, 0, 32'h0,        1, 32'h0000_1010, 32, 0, Z);
        add(1, 0, 32'h0,        0, Z,  0, 0,   1, 0, 32'h0,        0, 32'h0000_200C, 0,  0, Z);
        add(1, 0, 32'h0,        1, M0, 0, 0,   1, 1, 32'h0000_2000, 0, 32'h0000_200C, 0,  0, Z);
        add(1, 0, 32'h0,        1, M1, 1, 2,   1, 1, 32'h0000_2010, 0, 32'h0000_200C, 4,  0, Z);
        add(1, 1, 32'h0000_3000, 0, Z, 0, 0,   1, 0, 32'h0,        1, 32'h0000_200C, 20, 1, win(M0, M1, 12));
        add(1, 0, 32'h0,        0, Z,  0, 0,   1, 0, 32'h0,        0, 32'h0000_3000, 0,  0, Z);
        add(1, 1, 32'h0000_4000, 0, Z, 0, 0,   1, 1, 32'h0000_3000, 0, 32'h0000_3000, 0,  0, Z);
        add(1, 0, 32'h0,        0, Z,  0, 0,   1, 1, 32'h0000_3000, 0, 32'h0000_4000, 0,  0, Z);
        add(1, 0, 32'h0,        0, Z,  0, 0,   1, 1, 32'h0000_3000, 0, 32'h0000_4000, 0,  0, Z);
        add(1, 0, 32'h0,        1, S,  0, 0,   1, 1, 32'h0000_3000, 0, 32'h0000_4000, 0,  0, Z);
        add(1, 0, 32'h0,        1, N0, 0, 0,   1, 1, 32'h0000_4000, 0, 32'h0000_4000, 0,  0, Z);
        add(1, 0, 32'h0,        1, N1, 1, 5,   1, 1, 32'h0000_4010, 1, 32'h0000_4000, 16, 1, N0);
        add(1, 0, 32'h0,        0, Z,  1, 9,   1, 0, 32'h0,        1, 32'h0000_4005, 27, 1, win(N0, N1, 5));
        add(1, 0, 32'h0,        0, Z,  1, 5,   1, 0, 32'h0,        1, 32'h0000_400E, 18, 1, win(N0, N1, 14));
        add(1, 0, 32'h0,        1, N2, 1, 4,   1, 1, 32'h0000_4020, 0, 32'h0000_4013, 13, 0, Z);
        add(1, 1, 32'h0000_5000, 0, Z, 0, 0,   1, 0, 32'h0,        1, 32'h0000_4013, 29, 1, win(N2, N1, 19));
        add(1, 0, 32'h0,        0, Z,  0, 0,   1, 0, 32'h0,        0, 32'h0000_5000, 0,  0, Z);
        add(0, 0, 32'h0,        0, Z,  0, 0,   1, 1, 32'h0000_5000, 0, 32'h0000_5000, 0,  0, Z);
        add(1, 0, 32'h0,        1, S,  0, 0,   1, 0, 32'h0,        0, 32'h0000_1000, 0,  0, Z);
        add(1, 0, 32'h0,        1, L0, 0, 0,   1, 1, 32'h0000_1000, 0, 32'h0000_1000, 0,  0, Z);
        add(1, 1, 32'h0000_6000, 1, S, 0, 0,   1, 1, 32'h0000_1010, 1, 32'h0000_1000, 16, 1, L0);
        add(1, 0, 32'h0,        1, P0, 0, 0,   1, 1, 32'h0000_6000, 0, 32'h0000_6000, 0,  0, Z);
        add(1, 1, 32'hFFFF_FFF8, 0, Z, 0, 0,   1, 1, 32'h0000_6010, 1, 32'h0000_6000, 16, 1, P0);
        add(1, 0, 32'h0,        1, S,  0, 0,   1, 1, 32'h0000_6010, 0, 32'hFFFF_FFF8, 0,  0, Z);
        add(1, 0, 32'h0,        1, Q0, 0, 0,   1, 1, 32'hFFFF_FFF0, 0, 32'hFFFF_FFF8, 0,  0, Z);
        add(1, 0, 32'h0,        1, Q1, 0, 0,   1, 1, 32'h0000_0000, 0, 32'hFFFF_FFF8, 8,  0, Z);
        add(1, 0, 32'h0,        0, Z,  1, 10,  1, 0, 32'h0,        1, 32'hFFFF_FFF8, 24, 1, win(Q0, Q1, 8));
        add(1, 0, 32'h0,        0, Z,  0, 0,   1, 1, 32'h0000_0010, 0, 32'h0000_0002, 14, 0, Z);

        drive_idle();
        for (int r = 0; r < tv.size(); r++) begin
            @(negedge clk);
            if (tv[r].chk) begin
                cmp("req", r, ICACHE_RD_REQ, tv[r].ereq);
                if (tv[r].ereq) cmp("addr", r, ICACHE_RD_ADDR, tv[r].eaddr);
                cmp("ir_v", r, IR_V, tv[r].eirv);
                cmp("eip", r, EIP_OUT, tv[r].eeip);
                cmp("q_bytes", r, Q_BYTES, tv[r].eq);
                if (tv[r].chk_ir) cmp("ir", r, IR, tv[r].eir);
            end
            reset = tv[r].rst_n; FLUSH = tv[r].fl; FLUSH_EIP = tv[r].feip;
            ICACHE_RD_ACK = tv[r].ack; ICACHE_RD_DATA = tv[r].data;
            D1_ADVANCE = tv[r].adv; instr_length_updt = tv[r].len;
        end

        // Flush to a mid-line EIP while a request is in flight, then refill two lines.
        FLUSH = 1'b1; FLUSH_EIP = 32'h0000_7004; ICACHE_RD_ACK = 1'b0; D1_ADVANCE = 1'b0;
        @(negedge clk);
        FLUSH = 1'b0;
        cmp("discard_req", 100, ICACHE_RD_REQ, 1'b1);
        cmp("discard_addr", 100, ICACHE_RD_ADDR, 32'h0000_0010);
        ICACHE_RD_ACK = 1'b1; ICACHE_RD_DATA = S;
        @(negedge clk);
        ICACHE_RD_ACK = 1'b0;
        n = 0;
        while (!(ICACHE_RD_REQ && ICACHE_RD_ADDR == 32'h0000_7000) && n < 8) begin
            @(negedge clk);
            n++;
        end
        cmp("req_timeout", 101, (n < 8), 1'b1);
        ICACHE_RD_ACK = 1'b1; ICACHE_RD_DATA = R0;
        @(negedge clk);
        cmp("q_one_line", 102, Q_BYTES, 6'd12);
        cmp("irv_one_line", 102, IR_V, 1'b0);
        cmp("addr_second", 102, ICACHE_RD_ADDR, 32'h0000_7010);
        ICACHE_RD_DATA = R1;
        @(negedge clk);
        ICACHE_RD_ACK = 1'b0;
        cmp("irv_two_lines", 103, IR_V, 1'b1);
        cmp("ir_two_lines", 103, IR, win(R0, R1, 4));
        cmp("eip_two_lines", 103, EIP_OUT, 32'h0000_7004);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
